// File: rtl/k_invsqr_pkg.sv
// Shared FP16 constants, operand class enum and the elaboration-time
// reciprocal-square table generator for k_invsqr_pipe.
package k_invsqr_pkg;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int BIAS       = 15;
  localparam int LUT_W      = 12;  // {adj[1:0], frac[9:0]}

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    NORM = 2'd0,
    ZERO = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  // r = 1/mid^2 with mid = 1 + (seg+0.5)/2^seg_bits, evaluated exactly in
  // integers: mid = d/n with n = 2^(seg_bits+1), d = n + 2*seg + 1.
  // r is written as 1.frac * 2^-adj, frac rounded to nearest (no exact
  // ties exist because d is odd).
  function automatic logic [LUT_W-1:0] invsqr_lut_entry(input int seg, input int seg_bits);
    int n;
    int d;
    int n2;
    int d2;
    int adj;
    int num;
    int q;
    logic [LUT_W-1:0] ent;
    n   = 1 << (seg_bits + 1);
    d   = n + 2 * seg + 1;
    n2  = n * n;
    d2  = d * d;
    adj = (2 * n2 >= d2) ? 1 : 2;
    num = (n2 << adj) * 1024;
    q   = (2 * num + d2) / (2 * d2);
    // Rounding up to 2.0 renormalises to the next binade.
    if (q >= 2048) begin
      adj = adj - 1;
      q   = 1024;
    end
    ent[11:10] = adj[1:0];
    ent[9:0]   = q[9:0];
    return ent;
  endfunction

endpackage

// File: rtl/k_invsqr_lut.sv
// Combinational segment -> {adj, frac} ROM for the inverse-square mantissa.
// Contents are fixed at elaboration from invsqr_lut_entry().
module k_invsqr_lut
  import k_invsqr_pkg::*;
#(
  parameter int SEG_BITS = 4
) (
  input  logic [SEG_BITS-1:0] seg,
  output logic [LUT_W-1:0]    entry
);

  logic [LUT_W-1:0] rom [2**SEG_BITS];

  for (genvar i = 0; i < 2**SEG_BITS; i++) begin : g_rom
    assign rom[i] = invsqr_lut_entry(i, SEG_BITS);
  end

  // Plain table read
  assign entry = rom[seg];

endmodule

// File: rtl/k_invsqr_pipe.sv
// Pipelined FP16 approximate inverse-square (out ~= 1/x^2).
// Stages: S1 classify, S2 LUT lookup + exponent, S3 pack into output register.
// Optional build macro: INVSQR_STATS_EN adds saturating ovf/unf/nan counters.
//
// Handshake: a transfer happens on valid && ready at the rising edge; the
// whole pipe advances only when en = !out_valid || out_ready, in_ready = en
// (combinational), and the output register holds while out_valid && !out_ready.
module k_invsqr_pipe
  import k_invsqr_pkg::*;
#(
  parameter int SEG_BITS = 4,
  parameter int TAG_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_flags
`ifdef INVSQR_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [15:0]      stat_ovf_cnt,
  output logic [15:0]      stat_unf_cnt,
  output logic [15:0]      stat_nan_cnt
`endif
);

  localparam logic signed [7:0] EXP_OFS = 8'(3 * BIAS);  // BIAS + 2*BIAS

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // The sign never matters: x^2 is non-negative.
  logic unused_sign;
  assign unused_sign = in_data[15];

  // ---------------- S1: classify ----------------
  fp_class_e               cls_c;
  logic                    s1_valid;
  fp_class_e               s1_cls;
  logic [FP16_EXP_W-1:0]   s1_exp;
  logic [SEG_BITS-1:0]     s1_seg;
  logic [TAG_W-1:0]        s1_tag;

  // Operand class from exponent/mantissa fields; subnormals count as zero
  always_comb begin
    cls_c = NORM;
    if (in_data[14:10] == 5'h1F) begin
      cls_c = (in_data[9:0] != 10'd0) ? NAN : INF;
    end else if (in_data[14:10] == 5'h00) begin
      cls_c = ZERO;
    end
  end

  // S1 register: class, biased exponent, mantissa segment index, tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cls   <= NORM;
      s1_exp   <= '0;
      s1_seg   <= '0;
      s1_tag   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cls <= cls_c;
        s1_exp <= in_data[14:10];
        s1_seg <= in_data[9:10-SEG_BITS];
        s1_tag <= in_tag;
      end
    end
  end

  // ---------------- S2: lookup ----------------
  logic [LUT_W-1:0]        lut_entry;
  logic signed [7:0]       exp_c;
  logic                    s2_valid;
  fp_class_e               s2_cls;
  logic signed [7:0]       s2_exp;
  logic [FP16_MAN_W-1:0]   s2_frac;
  logic [TAG_W-1:0]        s2_tag;

  k_invsqr_lut #(
    .SEG_BITS (SEG_BITS)
  ) u_lut (
    .seg   (s1_seg),
    .entry (lut_entry)
  );

  // Result exponent E = 45 - 2e - adj, signed so under/overflow is visible
  always_comb begin
    exp_c = EXP_OFS - $signed({2'b00, s1_exp, 1'b0}) - $signed({6'd0, lut_entry[11:10]});
  end

  // S2 register: class, signed result exponent, mantissa fraction, tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_cls   <= NORM;
      s2_exp   <= '0;
      s2_frac  <= '0;
      s2_tag   <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_cls  <= s1_cls;
        s2_exp  <= exp_c;
        s2_frac <= lut_entry[9:0];
        s2_tag  <= s1_tag;
      end
    end
  end

  // ---------------- S3: pack ----------------
  logic [15:0] pack_data;
  logic [2:0]  pack_flags;

  // Special classes first, then exponent range checks, then the normal pack
  always_comb begin
    pack_data  = FP16_ZERO;
    pack_flags = 3'b000;
    case (s2_cls)
      NAN: begin
        pack_data  = FP16_QNAN;
        pack_flags = 3'b100;
      end
      ZERO: begin
        pack_data  = FP16_PINF;
        pack_flags = 3'b010;
      end
      INF: begin
        pack_data  = FP16_ZERO;
        pack_flags = 3'b001;
      end
      default: begin
        if (s2_exp > 8'sd30) begin
          pack_data  = FP16_PINF;
          pack_flags = 3'b010;
        end else if (s2_exp < 8'sd1) begin
          pack_data  = FP16_ZERO;
          pack_flags = 3'b001;
        end else begin
          pack_data  = {1'b0, s2_exp[4:0], s2_frac};
          pack_flags = 3'b000;
        end
      end
    endcase
  end

  // Output register: advances with the pipe, holds while stalled downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= FP16_ZERO;
      out_tag   <= '0;
      out_flags <= 3'b000;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data  <= pack_data;
        out_tag   <= s2_tag;
        out_flags <= pack_flags;
      end
    end
  end

`ifdef INVSQR_STATS_EN
  logic out_xfer;
  assign out_xfer = out_valid && out_ready;

  // Saturating per-flag transfer counters; clear beats a same-cycle count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ovf_cnt <= '0;
      stat_unf_cnt <= '0;
      stat_nan_cnt <= '0;
    end else if (stat_clr) begin
      stat_ovf_cnt <= '0;
      stat_unf_cnt <= '0;
      stat_nan_cnt <= '0;
    end else if (out_xfer) begin
      if (out_flags[1] && (stat_ovf_cnt != 16'hFFFF)) stat_ovf_cnt <= stat_ovf_cnt + 16'd1;
      if (out_flags[0] && (stat_unf_cnt != 16'hFFFF)) stat_unf_cnt <= stat_unf_cnt + 16'd1;
      if (out_flags[2] && (stat_nan_cnt != 16'hFFFF)) stat_nan_cnt <= stat_nan_cnt + 16'd1;
    end
  end
`endif

endmodule
